cpu_mem_bridge: RTL and testbench

Memory-side neighbour of the five-stage core: consumes the core's instruction-fetch and data-access SRAM-style ports and serialises them onto one valid/ready memory bus with a separate response channel. The data access is issued first, then the instruction fetch. `cpu_stall` is held high until both have completed, so the core can freeze its pipeline registers. Read data is registered and held stable for the core until the next accepted access.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/bus_req_chan.sv | 60 ++++++
 rtl/cpu_mem_bridge.sv | 151 +++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the core-to-memory bridge: FSM encoding,
// bus request layout and the fill value used when a response never arrives.
package cpu_mem_pkg;

  localparam int unsigned BUS_ADDR_W  = 32;
  localparam int unsigned BUS_DATA_W  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [BUS_DATA_W-1:0] ZERO_FILL = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_RESP = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_RESP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0]            we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_req_chan.sv
// Request side of the memory bus: holds valid/we/addr/wdata stable until the
// slave accepts, and counts cycles spent waiting for the matching response.
module bus_req_chan
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = BUS_ADDR_W,
  parameter int unsigned DATA_W  = BUS_DATA_W,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              launch,
  input  logic [3:0]        launch_we,
  input  logic [ADDR_W-1:0] launch_addr,
  input  logic [DATA_W-1:0] launch_wdata,
  input  logic              cnt_en,
  output logic              accepted,
  output logic              at_limit,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [3:0]        bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  assign accepted = bus_req_valid && bus_req_ready;
  assign at_limit = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_req_valid <= 1'b0;
      bus_req_we    <= 4'h0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
    end else if (launch) begin
      bus_req_valid <= 1'b1;
      bus_req_we    <= launch_we;
      bus_req_addr  <= launch_addr;
      bus_req_wdata <= launch_wdata;
    end else if (accepted) begin
      bus_req_valid <= 1'b0;
    end
  end

  // Restarted at acceptance so it measures only the response wait.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= 8'd0;
    end else if (accepted) begin
      wait_cnt <= 8'd0;
    end else if (cnt_en) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Serialises the core's data access and instruction fetch onto one valid/ready
// memory bus, data first, stalling the core until both have completed.
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = BUS_ADDR_W,
  parameter int unsigned DATA_W  = BUS_DATA_W,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req_en,
  input  logic [ADDR_W-1:0] inst_req_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req_en,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              cpu_stall,
  output logic              bus_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [3:0]        bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_rdata
);

  state_e            state, state_nxt;
  logic              take;
  logic              lat_i_pend;
  logic [3:0]        lat_wen;
  logic [ADDR_W-1:0] lat_i_addr;
  logic              launch;
  bus_req_t          launch_req;
  logic              accepted, at_limit;
  logic              resp_st, cnt_en, tmo;
  logic              d_load, i_load;
  logic [DATA_W-1:0] load_val;

  assign take    = (state == ST_IDLE) && (data_req_en || inst_req_en);
  assign resp_st = (state == ST_D_RESP) || (state == ST_I_RESP);
  assign cnt_en  = resp_st && !bus_resp_valid;
  assign tmo     = cnt_en && at_limit;
  assign load_val = tmo ? DATA_W'(ZERO_FILL) : bus_resp_rdata;

  assign cpu_stall = ((state != ST_IDLE) && (state != ST_DONE)) || take;

  always_comb begin
    state_nxt        = state;
    launch           = 1'b0;
    launch_req.we    = data_wen;
    launch_req.addr  = data_addr;
    launch_req.wdata = data_wdata;
    d_load           = 1'b0;
    i_load           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_req_en) begin
          state_nxt = ST_D_REQ;
          launch    = 1'b1;
        end else if (inst_req_en) begin
          state_nxt        = ST_I_REQ;
          launch           = 1'b1;
          launch_req.we    = 4'h0;
          launch_req.addr  = inst_req_addr;
          launch_req.wdata = '0;
        end
      end
      ST_D_REQ: if (accepted) state_nxt = ST_D_RESP;
      ST_D_RESP: begin
        if (bus_resp_valid || tmo) begin
          // A store has no read target, so data_rdata is left alone.
          d_load = (lat_wen == 4'h0);
          if (lat_i_pend) begin
            state_nxt        = ST_I_REQ;
            launch           = 1'b1;
            launch_req.we    = 4'h0;
            launch_req.addr  = lat_i_addr;
            launch_req.wdata = '0;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_I_REQ: if (accepted) state_nxt = ST_I_RESP;
      ST_I_RESP: begin
        if (bus_resp_valid || tmo) begin
          i_load    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      lat_i_pend <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) lat_i_pend <= inst_req_en;
      if (tmo || (bus_resp_valid && !resp_st)) bus_err <= 1'b1;
    end
  end

  // Request fields are only read after being sampled, so they need no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      lat_wen    <= data_wen;
      lat_i_addr <= inst_req_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      if (d_load) data_rdata <= load_val;
      if (i_load) inst_rdata <= load_val;
    end
  end

  bus_req_chan #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_req_chan (
    .clk           (clk),
    .resetn        (resetn),
    .launch        (launch),
    .launch_we     (launch_req.we),
    .launch_addr   (launch_req.addr),
    .launch_wdata  (launch_req.wdata),
    .cnt_en        (cnt_en),
    .accepted      (accepted),
    .at_limit      (at_limit),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata)
  );

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: scoreboarded memory-side responder plus
// core-side transactions checking stall length and returned data.
module tb_cpu_mem_bridge;
  import cpu_mem_pkg::*;

  typedef struct {
    logic        en;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req_en;
  logic [31:0] inst_req_addr;
  logic [31:0] inst_rdata;
  logic        data_req_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        cpu_stall;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [3:0]  bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  bus_req_t req_q[$];
  rsp_t     rsp_q[$];
  int       hold_cnt  = 0;
  logic     resp_next = 1'b0;
  logic     stray_req = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req_en    (inst_req_en),
    .inst_req_addr  (inst_req_addr),
    .inst_rdata     (inst_rdata),
    .data_req_en    (data_req_en),
    .data_wen       (data_wen),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .cpu_stall      (cpu_stall),
    .bus_err        (bus_err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_we     (bus_req_we),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wdata  (bus_req_wdata),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_rdata (bus_resp_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Memory slave: checks each presented request against the scoreboard,
  // holds ready low for hold_cnt cycles, answers one cycle after acceptance.
  initial begin : responder
    bus_req_t e;
    rsp_t     r;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus_resp_valid = 1'b0;
      if (resp_next) begin
        resp_next = 1'b0;
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          bus_resp_valid = r.en;
          bus_resp_rdata = r.data;
        end
      end
      if (stray_req) begin
        stray_req      = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hDEAD_BEEF;
      end
      if (bus_req_valid === 1'b1) begin
        if (req_q.size() == 0) begin
          check_eq("unexpected_req", 1, 0);
          bus_req_ready = 1'b1;
        end else begin
          e = req_q[0];
          check_eq("req_we",    bus_req_we,    e.we);
          check_eq("req_addr",  bus_req_addr,  e.addr);
          check_eq("req_wdata", bus_req_wdata, e.wdata);
          if (hold_cnt > 0) begin
            hold_cnt--;
            bus_req_ready = 1'b0;
          end else begin
            bus_req_ready = 1'b1;
            void'(req_q.pop_front());
            resp_next = 1'b1;
          end
        end
      end else begin
        bus_req_ready = 1'b0;
      end
    end
  end

  task automatic run_txn(input string tag,
                         input logic d_en, input logic [3:0] wen,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input logic d_rsp_en, input logic [31:0] drsp,
                         input logic i_en, input logic [31:0] iaddr,
                         input logic i_rsp_en, input logic [31:0] irsp,
                         input int hold, input int exp_stall);
    int   n;
    logic done;
    bus_req_t q;
    rsp_t     r;
    if (d_en) begin
      q.we = wen; q.addr = daddr; q.wdata = wdata;
      req_q.push_back(q);
      r.en = d_rsp_en; r.data = drsp;
      rsp_q.push_back(r);
    end
    if (i_en) begin
      q.we = 4'h0; q.addr = iaddr; q.wdata = '0;
      req_q.push_back(q);
      r.en = i_rsp_en; r.data = irsp;
      rsp_q.push_back(r);
    end
    hold_cnt = hold;
    @(negedge clk);
    data_req_en   = d_en;
    data_wen      = wen;
    data_addr     = daddr;
    data_wdata    = wdata;
    inst_req_en   = i_en;
    inst_req_addr = iaddr;
    #1;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (cpu_stall !== 1'b1) begin
        done = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_completed"}, done, 1'b1);
    check_eq({tag, "_stall_cycles"}, n, exp_stall);
    data_req_en = 1'b0;
    inst_req_en = 1'b0;
    @(negedge clk);
    #1;
    check_eq({tag, "_idle_stall"}, cpu_stall, 1'b0);
    check_eq({tag, "_req_q_empty"}, req_q.size(), 0);
    check_eq({tag, "_rsp_q_empty"}, rsp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, bus_req_valid, 1'b0);
    check_eq({tag, "_we"},    bus_req_we,    4'h0);
    check_eq({tag, "_addr"},  bus_req_addr,  32'h0);
    check_eq({tag, "_wdata"}, bus_req_wdata, 32'h0);
    check_eq({tag, "_inst"},  inst_rdata,    32'h0);
    check_eq({tag, "_data"},  data_rdata,    32'h0);
    check_eq({tag, "_err"},   bus_err,       1'b0);
  endtask

  initial begin : main
    resetn        = 1'b0;
    inst_req_en   = 1'b0;
    inst_req_addr = '0;
    data_req_en   = 1'b0;
    data_wen      = 4'h0;
    data_addr     = '0;
    data_wdata    = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    check_eq("por_stall", cpu_stall, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    run_txn("fetch", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
            1'b1, 32'hBFC0_0000, 1'b1, 32'h2408_0001, 0, 3);
    check_eq("fetch_inst_rdata", inst_rdata, 32'h2408_0001);
    check_eq("fetch_err", bus_err, 1'b0);

    run_txn("ldfetch", 1'b1, 4'h0, 32'h8000_0010, 32'h0, 1'b1, 32'hCAFE_F00D,
            1'b1, 32'hBFC0_0004, 1'b1, 32'h3C1D_A000, 0, 5);
    check_eq("ldfetch_data_rdata", data_rdata, 32'hCAFE_F00D);
    check_eq("ldfetch_inst_rdata", inst_rdata, 32'h3C1D_A000);

    run_txn("store", 1'b1, 4'hF, 32'h8000_0040, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF,
            1'b0, 32'h0, 1'b0, 32'h0, 3, 6);
    check_eq("store_data_rdata_held", data_rdata, 32'hCAFE_F00D);
    check_eq("store_err", bus_err, 1'b0);

    run_txn("tmo", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
            1'b1, 32'hBFC0_0008, 1'b0, 32'h0, 0, 6);
    check_eq("tmo_err", bus_err, 1'b1);
    check_eq("tmo_inst_zero", inst_rdata, 32'h0);
    check_eq("tmo_data_held", data_rdata, 32'hCAFE_F00D);

    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst2");
    @(negedge clk);
    resetn = 1'b1;

    @(posedge clk);
    #1;
    stray_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("stray_err", bus_err, 1'b1);
    check_eq("stray_valid", bus_req_valid, 1'b0);
    check_eq("stray_stall", cpu_stall, 1'b0);

    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_txn("load", 1'b1, 4'h0, 32'h8000_0020, 32'h0, 1'b1, 32'h1111_2222,
            1'b0, 32'h0, 1'b0, 32'h0, 0, 3);
    check_eq("load_data_rdata", data_rdata, 32'h1111_2222);

    // Load whose response never comes; reset lands while waiting in D_RESP.
    begin
      bus_req_t q;
      rsp_t     r;
      q.we = 4'h0; q.addr = 32'h8000_0030; q.wdata = '0;
      req_q.push_back(q);
      r.en = 1'b0; r.data = '0;
      rsp_q.push_back(r);
    end
    @(negedge clk);
    data_req_en = 1'b1;
    data_wen    = 4'h0;
    data_addr   = 32'h8000_0030;
    data_wdata  = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("midrst_pre_stall", cpu_stall, 1'b1);
    check_eq("midrst_pre_valid", bus_req_valid, 1'b0);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    data_req_en = 1'b0;
    #1;
    check_eq("midrst_stall", cpu_stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    run_txn("postrst", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
            1'b1, 32'hBFC0_0100, 1'b1, 32'h0000_0013, 0, 3);
    check_eq("postrst_inst_rdata", inst_rdata, 32'h0000_0013);
    check_eq("postrst_err", bus_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
